mem_bus_bridge: RTL and testbench
=================================

Name: mem_bus_bridge

Overview:
- Multi-cycle bridge between the core's load/store ports and a slow handshaked memory bus.
- Sits directly downstream of the single-cycle core's MEM stage.
- Accepts one access at a time, holds the core with stall until the bus acknowledges, and returns latched load data.
- Checks word alignment and, optionally, times out bus transactions.

Parameters:
- W, 32, data/address word width.
- TIMEOUT, 255, bus-wait cycle limit before abort (used only with the optional feature); must be ≥1 and < 2^16.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- load_en  in  1  core load request; held stable while stall=1.
- l_addr  in  W  core load address.
- l_data  out  W  load data returned to the core.
- store_en  in  1  core store request; held stable while stall=1.
- s_addr  in  W  core store address.
- s_data  in  W  core store data.
- stall  out  1  freezes the core PC/regfile while high.
- bus_req  out  1  bus request.
- bus_we  out  1  1=write, 0=read.
- bus_addr  out  W  bus word address.
- bus_wdata  out  W  bus write data.
- bus_rdata  in  W  bus read data, valid when bus_ack=1.
- bus_ack  in  1  one-cycle bus completion pulse.
- err  out  1  one-cycle pulse on misaligned access, conflict or timeout.

Behaviour:
- States:
  - IDLE: no access in progress.
  - BUSY: bus_req asserted, waiting for ack.
  - DONE: one cycle, the core advances.
- Reset (rst=1 at an edge): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, l_data=0, err=0, timeout counter=0. Reset mid-BUSY drops bus_req at that edge; a later bus_ack is ignored in IDLE.
- stall is combinational: (load_en | store_en) & (state != DONE). It is 0 whenever no request is present.
- IDLE, request present, address aligned (addr[1:0]==0):
  - Latch bus_addr, bus_we=store_en, and bus_wdata=s_data (stores only).
  - Go to BUSY; bus_req=1 from the next cycle.
- Address selection: the latched address is s_addr if store_en, else l_addr.
- load_en & store_en both high: the store is performed, and err pulses in the cycle after entry to BUSY.
- IDLE, misaligned address: no bus transaction. l_data=0, err=1 for one cycle, next state DONE.
- BUSY:
  - bus_req, bus_we, bus_addr and bus_wdata are held constant.
  - On bus_ack=1: bus_req=0 at the same edge; for a read, l_data<=bus_rdata; go to DONE.
  - bus_ack in any state other than BUSY is ignored.
- DONE: stall=0 for exactly one cycle, then IDLE. A request still present in the following IDLE cycle is treated as a new access, so back-to-back accesses are supported.
- l_data holds its last value between loads; stores do not modify it.
- Minimum latency: request at cycle 0, bus_req in cycle 1, ack in cycle 1, DONE in cycle 2. The core is stalled for 2 cycles per access.
- bus_ack in the same cycle that BUSY is entered cannot occur, because bus_req is not yet visible to the bus.

Optional Feature:
- MEM_BUS_BRIDGE_TIMEOUT_EN
- Defined: a 16-bit counter clears on entry to BUSY and increments each BUSY cycle without ack. When it reaches TIMEOUT:
  - bus_req drops; a read writes 0 to l_data; err pulses one cycle; next state DONE.
  - An ack arriving in the same cycle as the timeout wins, with no err.
- Undefined: no counter; BUSY waits indefinitely for bus_ack.

Test Plan:
- Load l_addr=0x0000_0010, bus_ack at bus cycle 3, bus_rdata=0xDEAD_BEEF -> bus_req high 3 cycles, bus_we=0, bus_addr=0x10, stall high 4 cycles, l_data=0xDEAD_BEEF in DONE.
- Store s_addr=0x0000_0020, s_data=0x1234_5678, immediate ack -> bus_we=1, bus_wdata=0x1234_5678, stall 2 cycles, l_data unchanged, err=0.
- Load l_addr=0x0000_0013 -> no bus_req, err pulse 1 cycle, stall 1 cycle, l_data=0.
- Back-to-back load 0x4 then store 0x8, each acked in 1 cycle -> two distinct bus_req bursts separated by a DONE and an IDLE cycle, correct addresses and bus_we values.
- rst asserted in cycle 2 of BUSY, then bus_ack pulsed -> bus_req=0 after the edge, state IDLE, l_data=0, ack ignored.
- With MEM_BUS_BRIDGE_TIMEOUT_EN, TIMEOUT=4, load with no ack -> bus_req high 4 cycles, err pulse, l_data=0, stall released in DONE.

Source files
------------

// File: rtl/mem_bus_bridge.sv
// Multi-cycle bridge from the core load/store ports to a handshaked memory bus.
// Optional bus-wait abort is enabled with `define MEM_BUS_BRIDGE_TIMEOUT_EN.
module mem_bus_bridge #(
  parameter int W       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  input  logic [W-1:0] l_addr,
  output logic [W-1:0] l_data,
  input  logic         store_en,
  input  logic [W-1:0] s_addr,
  input  logic [W-1:0] s_data,
  output logic         stall,
  output logic         bus_req,
  output logic         bus_we,
  output logic [W-1:0] bus_addr,
  output logic [W-1:0] bus_wdata,
  input  logic [W-1:0] bus_rdata,
  input  logic         bus_ack,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic         req;
  logic [W-1:0] sel_addr;
  logic         aligned;
  logic         start;
  logic         timeout;

  assign req      = load_en | store_en;
  assign sel_addr = store_en ? s_addr : l_addr;
  assign aligned  = (sel_addr[1:0] == 2'b00);
  assign start    = (state == IDLE) && req && aligned;
  assign stall    = req && (state != DONE);

`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] to_cnt;

  // Counter value equals the number of unacknowledged BUSY cycles already elapsed.
  assign timeout = (state == BUSY) && !bus_ack && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (start) begin
      to_cnt <= '0;
    end else if (state == BUSY && !bus_ack) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      l_data    <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bus_addr <= sel_addr;
            bus_we   <= store_en;
            if (store_en) bus_wdata <= s_data;
            bus_req  <= 1'b1;
            // A simultaneous load is dropped in favour of the store and flagged.
            err      <= load_en & store_en;
            state    <= BUSY;
          end else if (req) begin
            l_data <= '0;
            err    <= 1'b1;
            state  <= DONE;
          end
        end
        BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) l_data <= bus_rdata;
            state   <= DONE;
          end else if (timeout) begin
            bus_req <= 1'b0;
            if (!bus_we) l_data <= '0;
            err     <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: directed vector table, reset corner
// sequence and randomized accesses against a transaction-level model.
module tb_mem_bus_bridge;

  localparam int W  = 32;
  localparam int TO = 4;
`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         load_en;
  logic [W-1:0] l_addr;
  logic [W-1:0] l_data;
  logic         store_en;
  logic [W-1:0] s_addr;
  logic [W-1:0] s_data;
  logic         stall;
  logic         bus_req;
  logic         bus_we;
  logic [W-1:0] bus_addr;
  logic [W-1:0] bus_wdata;
  logic [W-1:0] bus_rdata;
  logic         bus_ack;
  logic         err;

  mem_bus_bridge #(.W(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .l_addr    (l_addr),
    .l_data    (l_data),
    .store_en  (store_en),
    .s_addr    (s_addr),
    .s_data    (s_data),
    .stall     (stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_ldata;

  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] la;
    logic [31:0] sa;
    logic [31:0] sd;
    int          ack;        // bus cycle on which the responder acks
    logic [31:0] rd;
    int          exp_req;    // cycles with bus_req high
    int          exp_stall;  // cycles with stall high
    int          exp_err;    // cycles with err high
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ldata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [31:0] la,
                              input logic [31:0] sa, input logic [31:0] sd, input int ack,
                              input logic [31:0] rd, input int req, input int stl,
                              input int er, input logic we, input logic [31:0] addr,
                              input logic [31:0] ldat);
    vec_t v;
    v.ld = ld; v.st = st; v.la = la; v.sa = sa; v.sd = sd; v.ack = ack; v.rd = rd;
    v.exp_req = req; v.exp_stall = stl; v.exp_err = er; v.exp_we = we;
    v.exp_addr = addr; v.exp_wdata = sd; v.exp_ldata = ldat;
    return v;
  endfunction

  // Transaction-level expectation: one access costs one request cycle plus the
  // bus wait, misaligned accesses never reach the bus.
  function automatic vec_t predict(input vec_t v, input logic [31:0] prev_ldata);
    vec_t        r;
    logic [31:0] addr;
    bit          timed;
    int          n;
    r     = v;
    addr  = v.st ? v.sa : v.la;
    if (addr[1:0] != 2'b00) begin
      r.exp_req   = 0;
      r.exp_stall = 1;
      r.exp_err   = 1;
      r.exp_ldata = 32'h0;
    end else begin
      timed       = TO_EN && (v.ack > TO);
      n           = timed ? TO : v.ack;
      r.exp_req   = n;
      r.exp_stall = 1 + n;
      r.exp_err   = ((v.ld && v.st) ? 1 : 0) + (timed ? 1 : 0);
      r.exp_we    = v.st;
      r.exp_addr  = addr;
      r.exp_wdata = v.sd;
      r.exp_ldata = v.st ? prev_ldata : (timed ? 32'h0 : v.rd);
    end
    return r;
  endfunction

  // Present one access, act as the bus slave, and compare what was observed.
  task automatic run_access(input vec_t v, input string tag);
    int          cyc  = 0;
    int          drv  = 0;
    int          rc   = 0;
    int          sc   = 0;
    int          ec   = 0;
    bit          done = 1'b0;
    bit          bus_bad = 1'b0;
    logic        req_in_done = 1'b0;
    logic [31:0] ld_done = 32'h0;
    @(posedge clk); #1;
    load_en  = v.ld;
    store_en = v.st;
    l_addr   = v.la;
    s_addr   = v.sa;
    s_data   = v.sd;
    while (!done && cyc < 200) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      if (bus_req) begin
        drv++;
        bus_ack   = (drv == v.ack);
        bus_rdata = bus_ack ? v.rd : $urandom();
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = $urandom();
      end
      @(negedge clk);
      if (bus_req) begin
        rc++;
        if (bus_addr !== v.exp_addr || bus_we !== v.exp_we ||
            (v.exp_we && bus_wdata !== v.exp_wdata)) bus_bad = 1'b1;
      end
      if (err) ec++;
      if (stall) sc++;
      else begin
        done        = 1'b1;
        ld_done     = l_data;
        req_in_done = bus_req;
      end
      cyc++;
    end
    bus_ack = 1'b0;
    check({tag, " finished"}, 32'(done), 32'd1);
    check({tag, " req_cycles"}, rc, v.exp_req);
    check({tag, " stall_cycles"}, sc, v.exp_stall);
    check({tag, " err_cycles"}, ec, v.exp_err);
    check({tag, " bus_fields"}, 32'(bus_bad), 32'd0);
    check({tag, " req_in_done"}, 32'(req_in_done), 32'd0);
    check({tag, " l_data"}, ld_done, v.exp_ldata);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      load_en  = 1'b0;
      store_en = 1'b0;
      bus_ack  = 1'b0;
      @(negedge clk);
      check({tag, " idle stall"}, 32'(stall), 32'd0);
      check({tag, " idle bus_req"}, 32'(bus_req), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t dir [7];
    vec_t v;
    int   r;

    rst = 1'b1; load_en = 1'b0; store_en = 1'b0; l_addr = '0; s_addr = '0;
    s_data = '0; bus_rdata = '0; bus_ack = 1'b0;
    model_ldata = 32'h0;

    //          ld  st  la            sa            sd            ack rd            req stl err we  addr          l_data
    dir[0] = mk(1, 0, 32'h0000_0010, 32'h0,        32'h0,        3, 32'hDEAD_BEEF, 3, 4, 0, 0, 32'h0000_0010, 32'hDEAD_BEEF);
    dir[1] = mk(0, 1, 32'h0,        32'h0000_0020, 32'h1234_5678, 1, 32'h0,        1, 2, 0, 1, 32'h0000_0020, 32'hDEAD_BEEF);
    dir[2] = mk(1, 0, 32'h0000_0013, 32'h0,        32'h0,        1, 32'h0,        0, 1, 1, 0, 32'h0,        32'h0);
    dir[3] = mk(1, 0, 32'h0000_0004, 32'h0,        32'h0,        1, 32'hA5A5_0004, 1, 2, 0, 0, 32'h0000_0004, 32'hA5A5_0004);
    dir[4] = mk(0, 1, 32'h0,        32'h0000_0008, 32'h0BAD_F00D, 1, 32'h0,        1, 2, 0, 1, 32'h0000_0008, 32'hA5A5_0004);
    dir[5] = mk(1, 1, 32'h0000_0030, 32'h0000_0040, 32'h5555_AAAA, 2, 32'h0,        2, 3, 1, 1, 32'h0000_0040, 32'hA5A5_0004);
    dir[6] = mk(1, 0, 32'hFFFF_FFFC, 32'h0,        32'h0,        1, 32'hC0FF_EE00, 1, 2, 0, 0, 32'hFFFF_FFFC, 32'hC0FF_EE00);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset bus_req", 32'(bus_req), 32'd0);
    check("reset bus_we", 32'(bus_we), 32'd0);
    check("reset bus_addr", bus_addr, 32'h0);
    check("reset bus_wdata", bus_wdata, 32'h0);
    check("reset l_data", l_data, 32'h0);
    check("reset err", 32'(err), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors run back-to-back: each new request lands in the IDLE after DONE.
    for (int i = 0; i < 7; i++) run_access(dir[i], $sformatf("dir%0d", i));
    model_ldata = 32'hC0FF_EE00;
    idle_cycles(1, "post_dir");

    // Reset in the second BUSY cycle, then a stray ack that must be ignored.
    @(posedge clk); #1;
    load_en = 1'b1; l_addr = 32'h0000_0050;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midbusy bus_req before reset", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; load_en = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    @(negedge clk);
    check("midbusy bus_req after reset", 32'(bus_req), 32'd0);
    check("midbusy l_data after reset", l_data, 32'h0);
    check("midbusy stall after reset", 32'(stall), 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check("stray ack bus_req", 32'(bus_req), 32'd0);
    check("stray ack l_data", l_data, 32'h0);
    check("stray ack err", 32'(err), 32'd0);
    model_ldata = 32'h0;

    v = predict(mk(1, 0, 32'h0000_0054, 32'h0, 32'h0, 2, 32'h2468_ACE0, 0, 0, 0, 0, 32'h0, 32'h0), model_ldata);
    run_access(v, "after_reset");
    model_ldata = v.exp_ldata;

`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
    v = mk(1, 0, 32'h0000_0064, 32'h0, 32'h0, TO, 32'h0000_0077, TO, TO + 1, 0, 0, 32'h0000_0064, 32'h0000_0077);
    run_access(v, "ack_wins");
    v = mk(1, 0, 32'h0000_0060, 32'h0, 32'h0, 99, 32'h0, TO, TO + 1, 1, 0, 32'h0000_0060, 32'h0);
    run_access(v, "timeout");
    model_ldata = 32'h0;
`endif

    for (int i = 0; i < 40; i++) begin
      r      = int'($urandom_range(1, 3));
      v.ld   = r[0];
      v.st   = r[1];
      v.la   = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) v.la = v.la | 32'($urandom_range(1, 3));
      v.sa   = $urandom() & 32'hFFFF_FFFC;
      v.sd   = $urandom();
      v.ack  = int'($urandom_range(1, 6));
      v.rd   = $urandom();
      v      = predict(v, model_ldata);
      run_access(v, $sformatf("rnd%0d", i));
      model_ldata = v.exp_ldata;
      idle_cycles(int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
